// File: rtl/rd_burst_responder.sv
// rd_burst_responder: wait-state read target that answers a two-phase read controller with one data beat per read
// Ports: clk, rst_n (async active-low); rd/ds controller strobes; burst_len latched on the first issue cycle;
// err_clr clears the sticky error; ws wait-state request; rdata/rvalid beat data; done_pulse/burst_cnt burst
// completion; err sticky protocol error.
module rd_burst_responder #(
    parameter int DW = 8,
    parameter int LW = 4,
    parameter logic [DW-1:0] BASE = 'hA0,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd,
    input  logic          ds,
    input  logic [LW-1:0] burst_len,
    input  logic          err_clr,
    output logic          ws,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          done_pulse,
    output logic [CW-1:0] burst_cnt,
    output logic          err
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SAMPLE     = 2'd1;
    localparam logic [1:0] WAIT_ISSUE = 2'd2;
    localparam logic [1:0] WAIT_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d, idx_q, idx_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ws_q, ws_d, rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
    logic [LW-1:0] len_eff;

    // A zero length field is served as a single-beat burst.
    assign len_eff = (burst_len == '0) ? LW'(1) : burst_len;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        // SAMPLE always lasts one cycle, so ws only needs setting on entry to it.
        ws_d     = 1'b0;
        rvalid_d = 1'b0;
        done_d   = 1'b0;
        // A new error below overrides a coinciding clear.
        err_d    = err_q & ~err_clr;
        case (state_q)
            IDLE: begin
                if (ds) begin
                    err_d = 1'b1;
                end else if (rd) begin
                    len_d    = len_eff;
                    idx_d    = '0;
                    rdata_d  = BASE;
                    rvalid_d = 1'b1;
                    ws_d     = len_eff > LW'(1);
                    state_d  = SAMPLE;
                end
            end
            SAMPLE: begin
                if (rd && !ds) begin
                    state_d = ws_q ? WAIT_ISSUE : WAIT_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_ISSUE: begin
                if (rd && !ds) begin
                    idx_d    = idx_q + 1'b1;
                    rdata_d  = BASE + DW'(idx_d);
                    rvalid_d = 1'b1;
                    ws_d     = ({1'b0, idx_q} + (LW+1)'(2)) < {1'b0, len_q};
                    state_d  = SAMPLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                if (ds && !rd) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            ws_q     <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            ws_q     <= ws_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ws         = ws_q;
    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign done_pulse = done_q;
    assign burst_cnt  = cnt_q;
    assign err        = err_q;
endmodule

// File: tb/tb_rd_burst_responder.sv
// tb_rd_burst_responder: randomized controller-sequence bench against a burst-level reference model
module tb_rd_burst_responder;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int CW = 8;
    localparam logic [7:0] BASE = 8'hA0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd = 1'b0;
    logic          ds = 1'b0;
    logic          err_clr = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          ws, rvalid, done_pulse, err;
    logic [DW-1:0] rdata;
    logic [CW-1:0] burst_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    int exp_err = 0;

    rd_burst_responder #(.DW(DW), .LW(LW), .BASE(BASE), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rd(rd), .ds(ds), .burst_len(burst_len), .err_clr(err_clr),
        .ws(ws), .rdata(rdata), .rvalid(rvalid), .done_pulse(done_pulse), .burst_cnt(burst_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_out", {ws, rvalid, done_pulse}, 0);
        end
    endtask

    // Legal controller: N beats of (issue, sample), then a ds pulse.
    task automatic burst(input int l);
        int n;
        n = (l == 0) ? 1 : l;
        for (int k = 0; k < n; k++) begin
            rd = 1'b1;
            ds = 1'b0;
            burst_len = (k == 0) ? LW'(l) : LW'($urandom);
            @(negedge clk);
            check("beat_rvalid", rvalid, 1);
            check("beat_rdata", rdata, (BASE + k) % 256);
            check("beat_ws", ws, (k + 1 < n) ? 1 : 0);
            @(negedge clk);
        end
        rd = 1'b0;
        ds = 1'b1;
        @(negedge clk);
        ds = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        check("done_pulse", done_pulse, 1);
        check("burst_cnt", burst_cnt, exp_cnt);
        check("done_err", err, exp_err);
    endtask

    task automatic expect_err(input string tag);
        exp_err = 1;
        check(tag, err, 1);
        check({tag, "_cnt"}, burst_cnt, exp_cnt);
        check({tag, "_out"}, {ws, rvalid, done_pulse}, 0);
    endtask

    task automatic clear_err;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 0;
        check("err_clr", err, 0);
    endtask

    task automatic abort_in_sample;
        rd = 1'b1;
        burst_len = LW'($urandom_range(0, 15));
        @(negedge clk);
        check("abort_rvalid", rvalid, 1);
        rd = 1'b0;
        @(negedge clk);
        expect_err("abort_err");
    endtask

    task automatic ds_in_idle;
        ds = 1'b1;
        err_clr = 1'($urandom_range(0, 1));
        @(negedge clk);
        ds = 1'b0;
        err_clr = 1'b0;
        expect_err("ds_idle_err");
    endtask

    task automatic clash_in_wait_issue;
        rd = 1'b1;
        burst_len = LW'($urandom_range(2, 15));
        @(negedge clk);
        check("clash_ws", ws, 1);
        @(negedge clk);
        ds = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        ds = 1'b0;
        expect_err("clash_err");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", {ws, rdata, rvalid, done_pulse, burst_cnt, err}, 0);
        rst_n = 1'b1;
        idle(1);
        burst(1);
        burst(3);
        burst(0);
        idle(1);
        abort_in_sample();
        clear_err();
        burst(2);
        ds_in_idle();
        clear_err();
        clash_in_wait_issue();
        ds_in_idle();
        clear_err();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: ds_in_idle();
                1: abort_in_sample();
                2: clash_in_wait_issue();
                default: burst($urandom_range(0, 15));
            endcase
            if (exp_err != 0 && $urandom_range(0, 1) == 1) clear_err();
            idle($urandom_range(0, 2));
        end
        clear_err();
        rd = 1'b1;
        burst_len = 4'd3;
        @(negedge clk);
        check("rst_mid_ws", ws, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_out", {ws, rdata, rvalid, done_pulse, burst_cnt, err}, 0);
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 0;
        idle(1);
        for (int i = 0; i < 255; i++) burst(1);
        check("wrap_255", burst_cnt, 255);
        burst(1);
        check("wrap_0", burst_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rd_burst_responder.md
Name: rd_burst_responder

Overview:
- Downstream target of the two-phase read controller: watches `rd` and `ds` and returns one data beat per read.
- Drives the wait-state line `ws` so the controller repeats READ until the programmed burst length is reached.
- Counts completed bursts and flags protocol violations.
- Sits between the read controller and the data sink, standing in for a wait-state memory.

Parameters:
- DW, 8, read data width.
- LW, 4, burst length field width; maximum burst is 2^LW-1 beats.
- BASE, 8'hA0, data value of beat 0; beat k returns (BASE + k) mod 2^DW.
- CW, 8, width of the completed-burst counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd  input  1  controller read strobe; high for both cycles of every beat (issue cycle, sample cycle).
- ds  input  1  controller done strobe; one-cycle pulse after the last beat, `rd` low.
- burst_len  input  LW  beats per burst; sampled only on the first issue cycle of a burst.
- err_clr  input  1  synchronous clear of the sticky error flag.
- ws  output  1  wait-state request, registered; valid during the sample cycle.
- rdata  output  DW  beat data, registered.
- rvalid  output  1  one-cycle pulse, `rdata` valid.
- done_pulse  output  1  one-cycle pulse on burst completion.
- burst_cnt  output  CW  completed bursts, wraps modulo 2^CW.
- err  output  1  sticky protocol error.

Behaviour:

Controller protocol (decided):
- Each beat is two consecutive cycles with `rd`=1: an issue cycle, then a sample cycle.
- In the sample cycle the controller samples `ws`. If `ws`=1 the next cycle is a new issue cycle (`rd`=1). If `ws`=0 the next cycle is `ds`=1, `rd`=0.
- `rd` and `ds` are never high together in a legal sequence.

Reset:
- While `rst_n`=0: state=IDLE, `ws`=0, `rdata`=0, `rvalid`=0, `done_pulse`=0, `burst_cnt`=0, `err`=0, internal len=0, beat index=0.
- Reset takes effect immediately, mid-burst included. No partial-burst state survives.

State machine: IDLE, SAMPLE, WAIT_ISSUE, WAIT_DONE. All transitions are evaluated at the rising edge.
- IDLE:
  - `rd`=1: len <= (`burst_len`==0 ? 1 : `burst_len`); idx <= 0; `rdata` <= BASE; `rvalid` <= 1; `ws` <= (len>1); go to SAMPLE.
  - `ds`=1 with `rd`=0: `err` <= 1; stay in IDLE.
  - Otherwise stay in IDLE.
- SAMPLE (controller in its sample cycle, `ws` presented):
  - `rd`=1: `ws` <= 0; go to WAIT_ISSUE if `ws`=1, else go to WAIT_DONE.
  - `rd`=0: `err` <= 1, `ws` <= 0, go to IDLE (aborted burst, not counted).
- WAIT_ISSUE:
  - `rd`=1 and `ds`=0: idx <= idx+1; `rdata` <= BASE+idx+1; `rvalid` <= 1; `ws` <= (idx+2 < len); go to SAMPLE.
  - Anything else: `err` <= 1, go to IDLE.
- WAIT_DONE:
  - `ds`=1 and `rd`=0: `done_pulse` <= 1; `burst_cnt` <= `burst_cnt`+1; go to IDLE.
  - Anything else: `err` <= 1, go to IDLE, no count.

Outputs and timing rules:
- `ws` is 1 only while in SAMPLE. It is cleared on every exit from SAMPLE.
- `rvalid` and `done_pulse` are single-cycle pulses; default 0 every cycle.
- Latency: `rdata`/`rvalid` appear the cycle after the issue cycle, i.e. in the sample cycle. `done_pulse` appears the cycle after `ds`.
- A burst of N beats produces exactly N `rvalid` pulses with data BASE..BASE+N-1, computed mod 2^DW.
- `rd`=1 and `ds`=1 in the same cycle in any state: treated as an error. `err` <= 1, go to IDLE.
- `burst_len` changes mid-burst are ignored until the next IDLE issue.
- `err` stays 1 until `err_clr`=1 or reset. If `err_clr` and a new error coincide, the new error wins (`err` stays 1).
- `burst_cnt` wraps from 2^CW-1 to 0 with no flag.

Test Plan:
- `burst_len`=1; drive `rd` for 2 cycles then `ds` for 1 -> `ws`=0 in the sample cycle; one `rvalid` with `rdata`=0xA0; `done_pulse` once; `burst_cnt`=1; `err`=0.
- `burst_len`=3; model the controller looping on `ws` -> `ws`=1,1,0 in the three sample cycles; `rdata` 0xA0,0xA1,0xA2; `rd` high 6 consecutive cycles; `burst_cnt`+1.
- `burst_len`=0 -> behaves as length 1: single beat 0xA0, `ws`=0.
- `rd` drops after the issue cycle (during SAMPLE) -> `err`=1, state IDLE, no `done_pulse`; then `err_clr` pulse -> `err`=0; the next legal burst completes normally.
- `ds` pulse in IDLE, and `rd`+`ds` together in WAIT_ISSUE -> `err`=1 both times, `burst_cnt` unchanged.
- Assert `rst_n`=0 mid-burst (`ws`=1) -> all outputs 0 asynchronously. 256 legal bursts -> `burst_cnt` wraps 255->0.
